// File: rtl/duty_cycle_meter_avg.sv
// rtl/duty_cycle_meter_avg.sv - averaging duty-cycle / period meter with hysteresis comparator
//
// Measures the duty cycle and period of an ADC-sampled pulse waveform,
// averaged over 2^AVG_LOG2 consecutive periods. The results are returned
// through a valid/ack handshake.
//
// Ports:
//   i_clk_10m      10 MHz system clock
//   i_rst          asynchronous active-high reset
//   i_adc_data     ADC sample, one per clock
//   i_thr_high     rising threshold (latched when leaving IDLE)
//   i_thr_low      falling threshold (latched when leaving IDLE)
//   i_cont_mode    1 = re-arm automatically after ack, 0 = single-shot
//   i_start        single-shot trigger pulse
//   i_result_ack   consumer acknowledge
//   o_busy         high in any state other than IDLE/HOLD
//   o_result_valid result registers valid, held until acked
//   o_result_err   result is an error report
//   o_err_code     00 ok, 01 timeout/saturation, 10 period too short, 11 bad thresholds
//   o_duty_cycle   duty in 0.01 % units
//   o_period_avg   average period in clock cycles
//   o_high_avg     average high time in clock cycles
module duty_cycle_meter_avg #(
  parameter int ADC_W       = 10,
  parameter int CNT_W       = 24,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_MAX = 10_000_000,
  parameter int MIN_PERIOD  = 100
) (
  input  logic             i_clk_10m,
  input  logic             i_rst,
  input  logic [ADC_W-1:0] i_adc_data,
  input  logic [ADC_W-1:0] i_thr_high,
  input  logic [ADC_W-1:0] i_thr_low,
  input  logic             i_cont_mode,
  input  logic             i_start,
  input  logic             i_result_ack,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic             o_result_err,
  output logic [1:0]       o_err_code,
  output logic [15:0]      o_duty_cycle,
  output logic [CNT_W-1:0] o_period_avg,
  output logic [CNT_W-1:0] o_high_avg
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int NUM_W = SUM_W + 14;
  localparam int PH_W  = $clog2(TIMEOUT_MAX + 2);
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SYNC, S_MEAS, S_DIV, S_DONE, S_HOLD
  } state_t;

  state_t             r_state, w_next;
  logic [ADC_W-1:0]   r_adc_d1, r_thr_h, r_thr_l;
  logic               r_sig, r_sig_prev;
  logic [PH_W-1:0]    r_phase;
  logic [CNT_W-1:0]   r_pcnt, r_hcnt;
  logic [SUM_W-1:0]   r_psum, r_hsum, r_rem;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_step;
  logic [13:0]        r_quot;

  logic               w_fail;
  logic [1:0]         w_fail_code;
  logic [ADC_W-1:0]   w_thr_h, w_thr_l;
  logic               w_rise, w_timeout, w_sat, w_short, w_track, w_ge, w_bit;
  logic [NUM_W-1:0]   w_num;
  logic [13:0]        w_num_lo;
  logic [SUM_W-1:0]   w_rem_in, w_diff, w_rem_next;
  logic [SUM_W:0]     w_trial;
  logic [CNT_W-1:0]   w_pavg, w_havg;

  // In IDLE the comparator follows the live thresholds so that the level
  // seen on the first ARM cycle already reflects the values being latched.
  assign w_thr_h   = (r_state == S_IDLE) ? i_thr_high : r_thr_h;
  assign w_thr_l   = (r_state == S_IDLE) ? i_thr_low  : r_thr_l;
  assign w_rise    = r_sig & ~r_sig_prev;
  assign w_timeout = r_phase > PH_W'(TIMEOUT_MAX);
  assign w_sat     = &r_pcnt;
  assign w_track   = (r_state == S_ARM) || (r_state == S_SYNC) || (r_state == S_MEAS);
  assign w_pavg    = r_psum[SUM_W-1:AVG_LOG2];
  assign w_havg    = r_hsum[SUM_W-1:AVG_LOG2];
  assign w_short   = w_pavg < CNT_W'(MIN_PERIOD);

  // Restoring division of high_sum*10000 by period_sum. high_sum <= period_sum
  // keeps the quotient within 14 bits, so the partial remainder can start
  // directly from the numerator's upper bits without a separate load cycle.
  assign w_num      = NUM_W'(r_hsum) * NUM_W'(10000);
  assign w_num_lo   = w_num[13:0];
  assign w_rem_in   = (r_step == 4'd0) ? w_num[NUM_W-1:14] : r_rem;
  assign w_bit      = w_num_lo[4'd13 - r_step];
  assign w_trial    = {w_rem_in, w_bit};
  assign w_ge       = w_trial >= {1'b0, r_psum};
  assign w_diff     = w_trial[SUM_W-1:0] - r_psum;
  assign w_rem_next = w_ge ? w_diff : w_trial[SUM_W-1:0];

  assign o_busy = (r_state != S_IDLE) && (r_state != S_HOLD);

  always_comb begin
    w_next      = r_state;
    w_fail      = 1'b0;
    w_fail_code = 2'b00;
    case (r_state)
      S_IDLE: if (i_cont_mode || i_start) begin
        if (i_thr_low >= i_thr_high) begin
          w_fail = 1'b1; w_fail_code = 2'b11;
        end else begin
          w_next = S_ARM;
        end
      end
      S_ARM:  if (w_timeout) begin
        w_fail = 1'b1; w_fail_code = 2'b01;
      end else if (!r_sig) w_next = S_SYNC;
      S_SYNC: if (w_timeout) begin
        w_fail = 1'b1; w_fail_code = 2'b01;
      end else if (w_rise) w_next = S_MEAS;
      S_MEAS: if (w_timeout || w_sat) begin
        w_fail = 1'b1; w_fail_code = 2'b01;
      end else if (w_rise && (r_idx == LAST_IDX)) w_next = S_DIV;
      S_DIV:  if ((r_step == 4'd0) && w_short) begin
        w_fail = 1'b1; w_fail_code = 2'b10;
      end else if (r_step == 4'd13) w_next = S_DONE;
      S_DONE: w_next = S_HOLD;
      S_HOLD: if (i_result_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_fail) w_next = S_HOLD;
  end

  always_ff @(posedge i_clk_10m or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_adc_d1 <= '0; r_thr_h <= '0; r_thr_l <= '0;
      r_sig <= 1'b0; r_sig_prev <= 1'b0;
      r_phase <= '0; r_pcnt <= '0; r_hcnt <= '0;
      r_psum <= '0; r_hsum <= '0; r_rem <= '0;
      r_idx <= '0; r_step <= '0; r_quot <= '0;
      o_result_valid <= 1'b0; o_result_err <= 1'b0; o_err_code <= 2'b00;
      o_duty_cycle <= '0; o_period_avg <= '0; o_high_avg <= '0;
    end else begin
      r_state    <= w_next;
      r_adc_d1   <= i_adc_data;
      r_sig_prev <= r_sig;
      if (r_adc_d1 >= w_thr_h)      r_sig <= 1'b1;
      else if (r_adc_d1 <= w_thr_l) r_sig <= 1'b0;

      if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
        r_thr_h <= i_thr_high;
        r_thr_l <= i_thr_low;
      end

      if (!w_track || (w_next != r_state) || w_rise) r_phase <= '0;
      else                                           r_phase <= r_phase + 1'b1;

      // The cycle carrying a rise is the first cycle of the new period.
      if ((r_state == S_SYNC) && (w_next == S_MEAS)) begin
        r_psum <= '0; r_hsum <= '0; r_idx <= '0;
        r_pcnt <= CNT_W'(1); r_hcnt <= CNT_W'(1);
      end else if (r_state == S_MEAS) begin
        if (w_rise) begin
          r_psum <= r_psum + SUM_W'(r_pcnt);
          r_hsum <= r_hsum + SUM_W'(r_hcnt);
          r_pcnt <= CNT_W'(1);
          r_hcnt <= CNT_W'(r_sig);
          r_idx  <= r_idx + 1'b1;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
          r_hcnt <= r_hcnt + CNT_W'(r_sig);
        end
      end

      if (r_state == S_DIV) begin
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[12:0], w_ge};
        r_step <= r_step + 1'b1;
      end else begin
        r_step <= '0;
      end

      if (w_fail) begin
        o_result_valid <= 1'b1; o_result_err <= 1'b1; o_err_code <= w_fail_code;
        o_duty_cycle <= '0; o_period_avg <= '0; o_high_avg <= '0;
      end else if (r_state == S_DONE) begin
        o_result_valid <= 1'b1; o_result_err <= 1'b0; o_err_code <= 2'b00;
        o_duty_cycle <= {2'b00, r_quot};
        o_period_avg <= w_pavg;
        o_high_avg   <= w_havg;
      end else if ((r_state == S_HOLD) && i_result_ack) begin
        o_result_valid <= 1'b0;
      end
    end
  end

endmodule
